toeplitz_sum: RTL
=================

Name: toeplitz_sum

Overview:
- Downstream accumulator for the seed-shift stage of the Toeplitz hasher.
- Consumes one shifted-seed row per cycle while sum_en is high, plus one raw-data bit aligned with each row.
- XORs each row whose data bit is 1 into a W-bit accumulator, so after ROWS rows the accumulator holds the Toeplitz hash of the block.
- Also requests each new block from the shift stage (drives its shift_en) and hands finished hashes downstream with a valid/ready handshake.

Parameters:
- W, 3072: row and hash width in bits.
- ROWS, 4097: rows accumulated per block; default matches the shift stage's per-block row count.
- CW, $clog2(ROWS+1): row counter width (derived; do not override).

Ports:
- clk_in  input  1  clock; all logic on posedge.
- rst  input  1  reset, asynchronous, active-high.
- run  input  1  enable; while high, blocks are requested back-to-back.
- shift_en  output  1  request to the shift stage for the next block.
- shift_ack  input  1  shift stage has taken the seed (1-cycle pulse).
- sum_en  input  1  row valid from the shift stage.
- row  input  W  shifted-seed row, valid when sum_en=1.
- data_bit  input  1  raw-data bit paired with the current row, sampled when sum_en=1.
- hash_out  output  W  finished hash, stable while hash_valid=1.
- hash_valid  output  1  hash available.
- hash_ready  input  1  downstream accepts the hash.
- short_err  output  1  sticky: a block ended before ROWS rows (see Optional Feature).

Behaviour:
- Reset (async, rst=1): state=IDLE; shift_en=0, hash_valid=0, hash_out=0, short_err=0; accumulator=0, counter=0.
- IDLE:
  - acc<=0, cnt<=0.
  - If run=1, go to REQ.
- REQ:
  - shift_en=1 (registered; asserted the cycle after entering REQ, held until ack).
  - On shift_ack=1: shift_en<=0, go to WAITS.
- WAITS:
  - Wait for sum_en=1; go to ACC on the first sum_en cycle.
  - That first row is accumulated in the same cycle; no row is lost.
- ACC, each cycle with sum_en=1:
  - If data_bit=1, acc<=acc^row; else acc unchanged.
  - cnt<=cnt+1.
  - The row that brings cnt to ROWS is the last one. acc becomes final, hash_out<=final acc, hash_valid<=1, go to DONE.
  - Rows with sum_en=1 arriving after the ROWS-th row in the same burst are ignored.
- ACC, sum_en falls to 0 before ROWS rows: early termination.
  - hash_out<=acc as it stands; hash_valid<=1; go to DONE.
  - short_err behaviour per Optional Feature.
- Latency: hash_valid rises 1 cycle after the last accumulated row.
- DONE:
  - hash_out held; hash_valid=1 until a cycle with hash_ready=1.
  - On that cycle: hash_valid<=0, acc<=0, cnt<=0.
  - Then go to REQ if run=1, else IDLE.
  - hash_ready is sampled only while hash_valid=1; it has no effect elsewhere.
- run deasserted mid-block: the current block completes and is delivered; no new request is made.
- shift_en is never asserted while hash_valid=1. This gives single-hash buffering and backpressures the shift stage.
- Stray sum_en in IDLE or REQ is ignored (no accumulation).
- Reset mid-block: everything clears immediately; the partial hash is discarded.
- XOR only, no carries; widths are exact at W.

Optional Feature:
- Macro: TOEPLITZ_SUM_SHORT_ERR_EN.
- Defined:
  - short_err<=1 on early termination.
  - It stays set until rst.
  - The short hash is still delivered.
- Undefined:
  - short_err tied 0.
  - Early termination behaves identically otherwise.

Test Plan:
1. W=8, ROWS=4, run=1. After shift_ack, rows 0x01,0x02,0x04,0x08 with data bits 1,0,1,1 → hash_out=0x0D, hash_valid one cycle after the 4th row.
2. Same rows, all data bits 0 → hash_out=0x00, valid after exactly 4 rows. Then rows 0xFF×4 with bits 1,1,1,0 → 0xFF.
3. Backpressure: hold hash_ready=0 for 10 cycles after valid → hash_out stable, shift_en stays 0. Raise ready → valid drops next cycle, shift_en rises the cycle after.
4. Early stop: ROWS=4, sum_en high for 2 rows (0x03 bit 1, 0x05 bit 1) then low → hash_out=0x06, hash_valid=1. short_err=1 with macro defined, 0 without.
5. rst pulse after 2 of 4 rows → all outputs 0 immediately. With run=1 after release → shift_en reasserts, and the next full block hashes correctly from a clean accumulator.
6. run dropped during ACC → the block completes and is delivered. After the ready handshake the FSM sits in IDLE with shift_en=0.

Source files
------------

// File: rtl/toeplitz_sum.sv
// toeplitz_sum: XOR-accumulates data-selected seed rows into a W-bit Toeplitz hash per block.
// Ports: clk_in/rst (async active-high) clock and reset; run enables back-to-back blocks;
// shift_en/shift_ack request a block from the shift stage; sum_en/row/data_bit deliver rows;
// hash_out/hash_valid/hash_ready hand off the finished hash; short_err flags short blocks.
// Optional: define TOEPLITZ_SUM_SHORT_ERR_EN to make short_err a sticky short-block flag.
module toeplitz_sum #(
    parameter int W    = 3072,
    parameter int ROWS = 4097,
    parameter int CW   = $clog2(ROWS + 1)
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         run,
    output logic         shift_en,
    input  logic         shift_ack,
    input  logic         sum_en,
    input  logic [W-1:0] row,
    input  logic         data_bit,
    output logic [W-1:0] hash_out,
    output logic         hash_valid,
    input  logic         hash_ready,
    output logic         short_err
);
    typedef enum logic [2:0] {IDLE, REQ, WAITS, ACC, DONE} state_t;
    state_t state_q, state_d;
    logic [W-1:0] acc_q, acc_d, hash_q, hash_d, acc_nx;
    logic [CW-1:0] cnt_q, cnt_d, cnt_nx;
    logic shift_en_q, shift_en_d, valid_q, valid_d;
`ifdef TOEPLITZ_SUM_SHORT_ERR_EN
    logic err_q, err_d;
`endif
    always_comb begin
        acc_nx     = data_bit ? acc_q ^ row : acc_q;
        cnt_nx     = cnt_q + 1'b1;
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        hash_d     = hash_q;
        valid_d    = valid_q;
        shift_en_d = shift_en_q;
`ifdef TOEPLITZ_SUM_SHORT_ERR_EN
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = run ? REQ : IDLE;
            end
            REQ: begin
                shift_en_d = !shift_ack;
                state_d    = shift_ack ? WAITS : REQ;
            end
            // The first row is taken in WAITS itself, so both states share the row path.
            WAITS, ACC: begin
                if (sum_en) begin
                    acc_d   = acc_nx;
                    cnt_d   = cnt_nx;
                    state_d = ACC;
                    if (cnt_nx == CW'(ROWS)) begin
                        hash_d  = acc_nx;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end
                end else if (state_q == ACC) begin
                    hash_d  = acc_q;
                    valid_d = 1'b1;
                    state_d = DONE;
`ifdef TOEPLITZ_SUM_SHORT_ERR_EN
                    err_d   = 1'b1;
`endif
                end
            end
            DONE: begin
                if (hash_ready) begin
                    valid_d = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = run ? REQ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            hash_q     <= '0;
            valid_q    <= 1'b0;
            shift_en_q <= 1'b0;
`ifdef TOEPLITZ_SUM_SHORT_ERR_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            hash_q     <= hash_d;
            valid_q    <= valid_d;
            shift_en_q <= shift_en_d;
`ifdef TOEPLITZ_SUM_SHORT_ERR_EN
            err_q      <= err_d;
`endif
        end
    end
    assign shift_en   = shift_en_q;
    assign hash_out   = hash_q;
    assign hash_valid = valid_q;
`ifdef TOEPLITZ_SUM_SHORT_ERR_EN
    assign short_err  = err_q;
`else
    assign short_err  = 1'b0;
`endif
endmodule
